// File: rtl/div_ctrl_pkg.sv
// Shared state type, reset-default config and config legality check for div_ctrl.
package div_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam int unsigned DIV_RST  = 16;
    localparam int unsigned HIGH_RST = 8;

    function automatic logic cfg_legal(input int unsigned div, input int unsigned high);
        return (div >= 2) && (high >= 1) && (high < div);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Config handshake bundle between register logic (master) and div_ctrl (slave).
interface div_ctrl_if #(
    parameter int unsigned CW = 8
) ();
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_div;
    logic [CW-1:0] cfg_high;
    logic          cfg_err;

    modport master (output cfg_valid, cfg_div, cfg_high, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/div_period_cnt.sv
// Period counter: counts 0..div-1, flags the last cycle and registers the divided wave.
module div_period_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clear,
    input  logic [CW-1:0] div,
    input  logic [CW-1:0] high,
    output logic          wrap,
    output logic          div_out
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_out_q, div_out_d;

    always_comb begin
        wrap      = (cnt_q == div - CW'(1));
        cnt_d     = cnt_q;
        div_out_d = div_out_q;
        if (clear) begin
            cnt_d     = '0;
            div_out_d = 1'b0;
        end else if (enable) begin
            cnt_d     = wrap ? '0 : cnt_q + CW'(1);
            // cnt_d==0 always yields low, so a config swap at the wrap cannot glitch
            div_out_d = (cnt_d >= div - high);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
        end
    end

    assign div_out = div_out_q;

endmodule

// File: rtl/div_ctrl.sv
// Divider controller: start/stop FSM, shadowed config handshake, period counter.
// Optional burst mode is enabled by defining DIV_CTRL_BURST_EN.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    div_ctrl_if.slave  cfg,
    input  logic       start,
    input  logic       stop,
`ifdef DIV_CTRL_BURST_EN
    input  logic [7:0] burst_len,
    output logic       burst_done,
`endif
    output logic       div_out,
    output logic       period_done,
    output logic       busy
);
    state_e        state_q, state_d;
    logic [CW-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
    logic [CW-1:0] pend_div_q, pend_div_d, pend_high_q, pend_high_d;
    logic          pend_valid_q, pend_valid_d;
    logic          cfg_err_q, cfg_err_d;
    logic          accept, legal, wrap, clear, burst_hit;

    assign accept = cfg.cfg_valid && !pend_valid_q;
    assign legal  = cfg_legal(32'(cfg.cfg_div), 32'(cfg.cfg_high));

`ifdef DIV_CTRL_BURST_EN
    logic [7:0] burst_len_q, burst_cnt_q;
    logic       burst_done_q;

    assign burst_hit = (state_q == StRun) && wrap && (burst_len_q != 8'd0)
                       && (burst_cnt_q == burst_len_q - 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_len_q  <= 8'd0;
            burst_cnt_q  <= 8'd0;
            burst_done_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                burst_len_q <= burst_len;
                burst_cnt_q <= 8'd0;
            end else if (state_q == StRun && wrap) begin
                burst_cnt_q <= burst_cnt_q + 8'd1;
            end
            burst_done_q <= burst_hit;
        end
    end

    assign burst_done = burst_done_q;
`else
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun: begin
                if (burst_hit) state_d = StIdle;
                else if (stop) state_d = wrap ? StIdle : StDrain;
            end
            StDrain: if (wrap) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        act_div_d    = act_div_q;
        act_high_d   = act_high_q;
        pend_div_d   = pend_div_q;
        pend_high_d  = pend_high_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = accept && !legal;
        if (pend_valid_q && state_q != StIdle && wrap) begin
            act_div_d    = pend_div_q;
            act_high_d   = pend_high_q;
            pend_valid_d = 1'b0;
        end
        // Straight to active whenever the next cycle is idle, so pend never lingers in IDLE
        if (accept && legal) begin
            if (state_d == StIdle) begin
                act_div_d  = cfg.cfg_div;
                act_high_d = cfg.cfg_high;
            end else begin
                pend_div_d   = cfg.cfg_div;
                pend_high_d  = cfg.cfg_high;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            act_div_q    <= CW'(DIV_RST);
            act_high_q   <= CW'(HIGH_RST);
            pend_div_q   <= '0;
            pend_high_q  <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_div_q    <= act_div_d;
            act_high_q   <= act_high_d;
            pend_div_q   <= pend_div_d;
            pend_high_q  <= pend_high_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign clear = (state_q == StIdle) || (state_d == StIdle);

    div_period_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (!clear),
        .clear   (clear),
        .div     (act_div_q),
        .high    (act_high_q),
        .wrap    (wrap),
        .div_out (div_out)
    );

    assign period_done   = (state_q != StIdle) && wrap;
    assign busy          = (state_q != StIdle);
    assign cfg.cfg_ready = !pend_valid_q;
    assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Programmable clock-enable divider controller. It sequences a period counter that produces a divided square wave with run-time selectable period and high time. It accepts new settings through a valid/ready handshake and applies them only at period boundaries, so the output never glitches. It also controls start and graceful stop of the divider, and sits between the register/config logic and any logic clocked by the divided enable.

## Interface
- CW, 8: counter and config width; maximum period is 2^CW−1 clocks.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config slot free; reset 1.
- cfg_div  in  CW  period length in clocks.
- cfg_high  in  CW  high clocks per period.
- cfg_err  out  1  one-cycle pulse when an accepted config is illegal; reset 0.
- start  in  1  begin running; used in IDLE only.
- stop  in  1  finish the current period, then idle; used in RUN only.
- div_out  out  1  registered divided wave; reset 0.
- period_done  out  1  one-cycle pulse in the last cycle of each period; reset 0.
- busy  out  1  state is not IDLE; reset 0.

## Operation
- **Active config** resets to div=16, high=8.
- **Legal config:** 2 ≤ div and 1 ≤ high < div.
  - An illegal config still completes the handshake, pulses cfg_err on the next cycle and is discarded.
- **Shadow register:** one entry (pend). cfg_ready = !pend_valid.
  - IDLE: an accepted legal config is written straight to active.
  - RUN/DRAIN: an accepted legal config is written to pend.
- **Counter:** cnt counts 0..div−1 and wraps to 0.
  - div_out = (cnt ≥ div−high), registered so it aligns with cnt. Each period is low first, then high.
- **States:** IDLE, RUN, DRAIN.
  - IDLE→RUN on start. cnt←0, div_out←0.
  - RUN→DRAIN on stop when cnt≠div−1.
  - RUN→IDLE on stop when cnt==div−1.
  - DRAIN→IDLE at the edge after cnt==div−1. In IDLE, cnt=0 and div_out=0.
- **Wrap** (cnt==div−1 in RUN): if pend_valid, active←pend and pend_valid←0. The new period uses the new values from cnt=0.
- **Entering IDLE with pend_valid:** the pending config is applied on the same edge.
- **Ignored inputs:** start in RUN/DRAIN; stop in IDLE/DRAIN.
- **Reset:** rst_n low at any point forces IDLE, clears pend and restores the defaults.

## Timing
- Start sampled at edge k: the cycle after edge k has cnt=0 and div_out=0.
- div_out first goes high in cycle div−high after start.
- period_done is high in the same cycle as cnt==div−1.
- Config accepted in RUN: it takes effect at the first wrap after acceptance. If accepted in the wrap cycle itself, it waits for the following wrap.
- cfg_ready rises the cycle after pend is consumed.
- Config accepted in IDLE: it takes effect for a start in the next cycle or later.
- A config and start in the same IDLE cycle: the start uses the old active config, and the new config goes to pend.
- cfg_err has 1-cycle latency from acceptance.

## Configuration
- **DIV_CTRL_BURST_EN defined:**
  - Adds input burst_len [7:0] and output burst_done (reset 0).
  - Start latches burst_len. 0 means free-run.
  - Otherwise, after burst_len period_done pulses, the block goes directly RUN→IDLE. burst_done pulses for one cycle on that transition edge.
  - stop still ends a burst early via DRAIN; burst_done is not pulsed in that case.
- **Undefined:** always free-run; the ports and the burst counter are absent.

## Structure
- **Package div_ctrl_pkg:** state enum (IDLE/RUN/DRAIN), DIV_RST=16, HIGH_RST=8, and the legality-check function.
- **Sub-module div_period_cnt:** cnt, wrap detect and div_out register, with inputs enable, clear, div and high. The FSM, shadow register and handshake stay in div_ctrl.

## Test plan
- **Reset, start, no config:** div_out is 8 low / 8 high repeating; period_done every 16th cycle at cnt=15.
- **In IDLE, cfg div=5 high=2, then start:** div_out pattern 0,0,0,1,1 repeating; busy=1.
- **In RUN with div=16, cfg div=4 high=1 mid-period:** cfg_ready low until the wrap; the current 16-cycle period completes, then 0,0,0,1 repeats.
- **cfg div=3 high=3:** handshake completes; cfg_err pulses 1 cycle later; the active config is unchanged.
- **stop at cnt=5 with div=16:** DRAIN until cnt=15, then IDLE, div_out=0, busy=0. stop at cnt=15 goes to IDLE at the next edge.
- **rst_n low mid-DRAIN with pend valid:** the next cycle is IDLE, cfg_ready=1, and a subsequent start yields 16/8. With DIV_CTRL_BURST_EN, burst_len=3 gives exactly 3 periods and a burst_done pulse.
